// File: rtl/python_frame_packer_pkg.sv
// Shared types for the frame packer: FSM encoding, FIFO entry layout, counter helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package python_frame_packer_pkg;

    // Capture state machine, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FRAME = 2'd2,
        ST_DROP  = 2'd3
    } state_e;

    localparam int DATA_W = 64;

    // One FIFO entry: packed pixel pair plus three tags above the data.
    typedef struct packed {
        logic              eof;
        logic              eol;
        logic              sof;
        logic [DATA_W-1:0] dat;
    } entry_t;

    localparam int ENTRY_W     = $bits(entry_t);
    localparam int TAG_SOF_BIT = DATA_W;
    localparam int TAG_EOL_BIT = DATA_W + 1;
    localparam int TAG_EOF_BIT = DATA_W + 2;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/python_pack_fifo.sv
// Synchronous first-word-fall-through FIFO, W bits wide, 2**AW entries deep.
// Latency: a write is visible on rd_dat the cycle after it is accepted.
// Backpressure: writes are refused whenever full, even if a read happens the same cycle.
//
// Ports: clk/rst (sync, active-high), wr_vld/wr_dat write side, full;
//        rd_rdy/rd_dat read side (head shown while !empty, zero when empty), empty.
module python_pack_fifo #(
    parameter int W  = 67,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_wr;
    logic          do_rd;

    assign full  = (cnt_q == DEPTH_C);
    assign empty = (cnt_q == '0);
    // Full blocks the write regardless of a same-cycle read, so contents never change under overflow.
    assign do_wr = wr_vld & ~full;
    assign do_rd = rd_rdy & ~empty;
    // Zero the head while empty so reset and idle present clean data/tags.
    assign rd_dat = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/python_frame_packer.sv
// Packs pairs of 32-bit sensor words into tagged 64-bit FIFO entries (sof/eol/eof), with length checks.
// Latency: 3 cycles from the second word of a pair on d to the entry on out_data (FIFO empty).
// Backpressure: out_valid/out_ready; when the 2**FIFO_AW FIFO is full the rest of the frame is dropped.
//
// Ports: c clock, rst sync active-high; fv/lv/d sensor stream (pixel 0 in d[7:0]); en capture enable;
//        out_valid/out_ready/out_data/out_sof/out_eol/out_eof output stream;
//        frame_cnt completed frames; err_len/err_lines/overflow sticky error flags.
module python_frame_packer
    import python_frame_packer_pkg::*;
#(
    parameter int LINE_WORDS = 320,
    parameter int LINES      = 1024,
    parameter int FIFO_AW    = 4
) (
    input  logic        c,
    input  logic        rst,
    input  logic        fv,
    input  logic        lv,
    input  logic [31:0] d,
    input  logic        en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof,
    output logic [15:0] frame_cnt,
    output logic        err_len,
    output logic        err_lines,
    output logic        overflow
);

    localparam logic [15:0] LINE_WORDS_C = 16'(LINE_WORDS);
    localparam logic [15:0] LINES_C      = 16'(LINES);
    localparam logic [15:0] LAST_LINE_C  = 16'(LINES - 1);

    // Input stage.
    logic        fv_q, lv_q;
    logic [31:0] d_q;

    // Control and packing state.
    state_e      state_q, state_d;
    logic        hi_sel_q, hi_sel_d;       // next captured word goes to the high half
    logic [63:0] pack_q, pack_d;
    logic        push_pend_q, push_pend_d; // pack_q holds a complete entry to push this cycle
    logic        tag_sof_q, tag_sof_d;
    logic        tag_eol_q, tag_eol_d;
    logic        tag_eof_q, tag_eof_d;
    logic        sof_pend_q, sof_pend_d;   // no entry of the current frame pushed yet
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_len_q, err_len_d;
    logic        err_lines_q, err_lines_d;
    logic        overflow_q, overflow_d;

    // Derived strobes.
    logic        eol;
    logic        fv_rise;
    logic        fv_fall;
    logic        frame_eol;
    logic        capture;
    logic        push_blocked;
    logic [15:0] word_inc;
    logic [15:0] line_inc;
    logic [15:0] line_eff;

    // FIFO interface.
    entry_t             push_ent;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head_dat;

    // Edges are taken between the registered and the raw input, so each fires
    // in the cycle the registered value is about to change.
    assign eol     = lv_q & ~lv;
    assign fv_rise = fv & ~fv_q;
    assign fv_fall = fv_q & ~fv;

    assign push_blocked = push_pend_q & fifo_full;
    assign frame_eol    = (state_q == ST_FRAME) & eol;
    // A word arriving in the same cycle as a refused push is part of the dropped remainder.
    assign capture      = (state_q == ST_FRAME) & lv_q & ~push_blocked;
    assign word_inc     = sat_inc16(word_cnt_q);
    assign line_inc     = sat_inc16(line_cnt_q);
    // Line count including an eol that lands in the same cycle as the frame end.
    assign line_eff     = frame_eol ? line_inc : line_cnt_q;

    always_comb begin
        push_ent     = '0;
        push_ent.eof = tag_eof_q;
        push_ent.eol = tag_eol_q;
        push_ent.sof = tag_sof_q;
        push_ent.dat = pack_q;
    end

    always_comb begin
        state_d     = state_q;
        hi_sel_d    = hi_sel_q;
        pack_d      = pack_q;
        push_pend_d = 1'b0;
        tag_sof_d   = tag_sof_q;
        tag_eol_d   = tag_eol_q;
        tag_eof_d   = tag_eof_q;
        sof_pend_d  = sof_pend_q;
        // Cleared whenever the line is idle, so each line starts counting from zero.
        word_cnt_d  = lv_q ? word_inc : 16'd0;
        line_cnt_d  = line_cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_len_d   = err_len_q;
        err_lines_d = err_lines_q;
        overflow_d  = overflow_q | push_blocked;

        if (capture) begin
            if (hi_sel_q) begin
                pack_d[63:32] = d_q;
                push_pend_d   = 1'b1;
            end else begin
                // Writing the low half also zeroes the high half, which is the
                // padding when a line ends on an odd word.
                pack_d      = {32'd0, d_q};
                push_pend_d = eol;
            end
            // Every line starts packing in the low half.
            hi_sel_d = ~hi_sel_q & ~eol;
            if (push_pend_d) begin
                tag_sof_d  = sof_pend_q;
                tag_eol_d  = eol;
                tag_eof_d  = eol & (line_cnt_q == LAST_LINE_C);
                sof_pend_d = 1'b0;
            end
        end

        if (frame_eol) begin
            line_cnt_d = line_inc;
            if (word_inc != LINE_WORDS_C) begin
                err_len_d = 1'b1;
            end
        end

        case (state_q)
            ST_WAIT: begin
                if (!fv_q && en) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!en) begin
                    state_d = ST_WAIT;
                end else if (fv_rise) begin
                    state_d    = ST_FRAME;
                    line_cnt_d = 16'd0;
                    hi_sel_d   = 1'b0;
                    sof_pend_d = 1'b1;
                end
            end
            ST_FRAME: begin
                if (fv_fall) begin
                    // A refusal on the very last cycle loses data: treat it like a drop exit.
                    if (push_blocked) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d     = en ? ST_ARMED : ST_WAIT;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (line_eff != LINES_C) begin
                            err_lines_d = 1'b1;
                        end
                    end
                end else if (push_blocked) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (fv_fall) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge c) begin
        if (rst) begin
            // fv_q comes out of reset high: if the sensor is mid-frame it stays high and
            // WAIT holds until fv drops, so a partial frame can never look like a frame start.
            fv_q        <= 1'b1;
            lv_q        <= 1'b0;
            d_q         <= 32'd0;
            state_q     <= ST_WAIT;
            hi_sel_q    <= 1'b0;
            pack_q      <= 64'd0;
            push_pend_q <= 1'b0;
            tag_sof_q   <= 1'b0;
            tag_eol_q   <= 1'b0;
            tag_eof_q   <= 1'b0;
            sof_pend_q  <= 1'b0;
            word_cnt_q  <= 16'd0;
            line_cnt_q  <= 16'd0;
            frame_cnt_q <= 16'd0;
            err_len_q   <= 1'b0;
            err_lines_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            fv_q        <= fv;
            lv_q        <= lv;
            d_q         <= d;
            state_q     <= state_d;
            hi_sel_q    <= hi_sel_d;
            pack_q      <= pack_d;
            push_pend_q <= push_pend_d;
            tag_sof_q   <= tag_sof_d;
            tag_eol_q   <= tag_eol_d;
            tag_eof_q   <= tag_eof_d;
            sof_pend_q  <= sof_pend_d;
            word_cnt_q  <= word_cnt_d;
            line_cnt_q  <= line_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_len_q   <= err_len_d;
            err_lines_q <= err_lines_d;
            overflow_q  <= overflow_d;
        end
    end

    python_pack_fifo #(
        .W  (ENTRY_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk    (c),
        .rst    (rst),
        .wr_vld (push_pend_q),
        .wr_dat (push_ent),
        .full   (fifo_full),
        .rd_rdy (out_ready),
        .rd_dat (head_dat),
        .empty  (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head_dat[DATA_W-1:0];
    assign out_sof   = head_dat[TAG_SOF_BIT];
    assign out_eol   = head_dat[TAG_EOL_BIT];
    assign out_eof   = head_dat[TAG_EOF_BIT];
    assign frame_cnt = frame_cnt_q;
    assign err_len   = err_len_q;
    assign err_lines = err_lines_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_python_frame_packer.sv
// Directed bench for python_frame_packer with LINE_WORDS=4, LINES=2.
// Entries are logged as {eof,eol,sof,data} on every accepted transfer and compared to hand-built lists.
// Inputs change 1 ns after the rising edge; outputs are sampled there or on the falling edge.
`timescale 1ns/1ps
module tb_python_frame_packer;
    import python_frame_packer_pkg::*;

    logic        c;
    logic        rst;
    logic        fv;
    logic        lv;
    logic [31:0] d;
    logic        en;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;
    logic [15:0] frame_cnt;
    logic        err_len;
    logic        err_lines;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [66:0] rx_q[$];
    logic [66:0] exp_q[$];

    python_frame_packer #(
        .LINE_WORDS (4),
        .LINES      (2),
        .FIFO_AW    (4)
    ) dut (
        .c         (c),
        .rst       (rst),
        .fv        (fv),
        .lv        (lv),
        .d         (d),
        .en        (en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .frame_cnt (frame_cnt),
        .err_len   (err_len),
        .err_lines (err_lines),
        .overflow  (overflow)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    // Log every transfer that will happen at the next rising edge.
    always @(negedge c) begin
        if (out_valid && out_ready) begin
            rx_q.push_back({out_eof, out_eol, out_sof, out_data});
        end
    end

    task automatic check_eq(input string tag, input logic [66:0] got, input logic [66:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    // Present one cycle of sensor input; returns just after it has been sampled.
    task automatic step(input logic f, input logic l, input logic [31:0] v);
        fv = f;
        lv = l;
        d  = v;
        tick();
    endtask

    task automatic idle(input int n, input logic f);
        for (int i = 0; i < n; i++) begin
            step(f, 1'b0, 32'd0);
        end
    endtask

    task automatic send_line(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, base + 32'(i));
        end
        idle(2, 1'b1);
    endtask

    task automatic frame_begin();
        idle(3, 1'b0);
        idle(2, 1'b1);
    endtask

    task automatic frame_end();
        idle(3, 1'b0);
    endtask

    task automatic expect_e(input logic [31:0] hi, input logic [31:0] lo,
                            input logic s, input logic l, input logic f);
        exp_q.push_back({f, l, s, hi, lo});
    endtask

    task automatic compare_rx(input string tag);
        check_eq($sformatf("%s_count", tag), 67'(rx_q.size()), 67'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_entry%0d", tag, i), rx_q[i], exp_q[i]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [66:0] errs();
        return 67'({err_len, err_lines, overflow});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fv = 1'b0; lv = 1'b0; d = 32'd0; en = 1'b1; out_ready = 1'b0;
        repeat (3) tick();

        // Reset state.
        check_eq("rst_valid", 67'(out_valid), 67'(0));
        check_eq("rst_head", {out_eof, out_eol, out_sof, out_data}, 67'(0));
        check_eq("rst_frame_cnt", 67'(frame_cnt), 67'(0));
        check_eq("rst_errs", errs(), 67'(0));
        rst = 1'b0;

        // Frame of words 0..7 held with out_ready low; also measures latency and hold.
        frame_begin();
        step(1'b1, 1'b1, 32'd0);
        step(1'b1, 1'b1, 32'd1);            // second word of the pair sampled here
        step(1'b1, 1'b1, 32'd2);
        check_eq("lat_n2_valid", 67'(out_valid), 67'(0));
        step(1'b1, 1'b1, 32'd3);
        check_eq("lat_n3_valid", 67'(out_valid), 67'(1));
        check_eq("lat_n3_head", {out_eof, out_eol, out_sof, out_data}, {3'b001, 32'd1, 32'd0});
        idle(2, 1'b1);
        send_line(4, 32'd4);
        check_eq("hold_head", {out_eof, out_eol, out_sof, out_data}, {3'b001, 32'd1, 32'd0});
        frame_end();
        check_eq("t1_frame_cnt", 67'(frame_cnt), 67'(1));
        check_eq("t1_errs", errs(), 67'(0));
        out_ready = 1'b1;
        idle(8, 1'b0);
        expect_e(32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        expect_e(32'd3, 32'd2, 1'b0, 1'b1, 1'b0);
        expect_e(32'd5, 32'd4, 1'b0, 1'b0, 1'b0);
        expect_e(32'd7, 32'd6, 1'b0, 1'b1, 1'b1);
        compare_rx("t1");

        // Short line of three words: odd tail is zero padded, err_len raised.
        frame_begin();
        send_line(3, 32'hA00);
        send_line(4, 32'hB00);
        frame_end();
        idle(6, 1'b0);
        expect_e(32'hA01, 32'hA00, 1'b1, 1'b0, 1'b0);
        expect_e(32'h000, 32'hA02, 1'b0, 1'b1, 1'b0);
        expect_e(32'hB01, 32'hB00, 1'b0, 1'b0, 1'b0);
        expect_e(32'hB03, 32'hB02, 1'b0, 1'b1, 1'b1);
        compare_rx("t2");
        check_eq("t2_errs", errs(), 67'(3'b100));
        check_eq("t2_frame_cnt", 67'(frame_cnt), 67'(2));

        // Three lines: eof only on line index 1, err_lines at frame end.
        frame_begin();
        send_line(4, 32'hC00);
        send_line(4, 32'hD00);
        send_line(4, 32'hE00);
        frame_end();
        idle(6, 1'b0);
        expect_e(32'hC01, 32'hC00, 1'b1, 1'b0, 1'b0);
        expect_e(32'hC03, 32'hC02, 1'b0, 1'b1, 1'b0);
        expect_e(32'hD01, 32'hD00, 1'b0, 1'b0, 1'b0);
        expect_e(32'hD03, 32'hD02, 1'b0, 1'b1, 1'b1);
        expect_e(32'hE01, 32'hE00, 1'b0, 1'b0, 1'b0);
        expect_e(32'hE03, 32'hE02, 1'b0, 1'b1, 1'b0);
        compare_rx("t3");
        check_eq("t3_errs", errs(), 67'(3'b110));
        check_eq("t3_frame_cnt", 67'(frame_cnt), 67'(3));

        // 40-entry frame (10 lines of 8 words) with out_ready low: overflow and drop.
        out_ready = 1'b0;
        frame_begin();
        for (int l = 0; l < 10; l++) begin
            send_line(8, 32'h1000 + 32'(l * 16));
        end
        check_eq("t4_errs", errs(), 67'(3'b111));
        check_eq("t4_state", 67'(dut.state_q), 67'(ST_DROP));
        check_eq("t4_valid", 67'(out_valid), 67'(1));
        frame_end();
        check_eq("t4_frame_cnt", 67'(frame_cnt), 67'(3));
        out_ready = 1'b1;
        idle(24, 1'b0);
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 4; p++) begin
                expect_e(32'h1000 + 32'(l * 16 + 2 * p + 1), 32'h1000 + 32'(l * 16 + 2 * p),
                         (l == 0 && p == 0), (p == 3), (l == 1 && p == 3));
            end
        end
        compare_rx("t4");

        // The frame after an overflow is captured intact.
        frame_begin();
        send_line(4, 32'h2000);
        send_line(4, 32'h2100);
        frame_end();
        idle(6, 1'b0);
        expect_e(32'h2001, 32'h2000, 1'b1, 1'b0, 1'b0);
        expect_e(32'h2003, 32'h2002, 1'b0, 1'b1, 1'b0);
        expect_e(32'h2101, 32'h2100, 1'b0, 1'b0, 1'b0);
        expect_e(32'h2103, 32'h2102, 1'b0, 1'b1, 1'b1);
        compare_rx("t5");
        check_eq("t5_frame_cnt", 67'(frame_cnt), 67'(4));

        // Reset on word 3 of line 0: partial frame discarded, next frame normal.
        frame_begin();
        step(1'b1, 1'b1, 32'h3000);
        step(1'b1, 1'b1, 32'h3001);
        step(1'b1, 1'b1, 32'h3002);
        rst = 1'b1;
        step(1'b1, 1'b1, 32'h3003);
        rst = 1'b0;
        check_eq("t6_valid_after_rst", 67'(out_valid), 67'(0));
        check_eq("t6_frame_cnt_rst", 67'(frame_cnt), 67'(0));
        check_eq("t6_errs_rst", errs(), 67'(0));
        idle(2, 1'b1);
        send_line(4, 32'h3100);
        frame_end();
        idle(4, 1'b0);
        compare_rx("t6_aborted");
        frame_begin();
        send_line(4, 32'h4000);
        send_line(4, 32'h4100);
        frame_end();
        idle(6, 1'b0);
        expect_e(32'h4001, 32'h4000, 1'b1, 1'b0, 1'b0);
        expect_e(32'h4003, 32'h4002, 1'b0, 1'b1, 1'b0);
        expect_e(32'h4101, 32'h4100, 1'b0, 1'b0, 1'b0);
        expect_e(32'h4103, 32'h4102, 1'b0, 1'b1, 1'b1);
        compare_rx("t6");
        check_eq("t6_frame_cnt", 67'(frame_cnt), 67'(1));
        check_eq("t6_errs", errs(), 67'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
